axi4_stream_master_bram: RTL and testbench

AXI4_STREAM_MASTER_BRAM -- requirements
Module: axi4_stream_master_bram

---
 rtl/axis_bram_pkg.sv | 14 +
 rtl/axis_skid_fifo2.sv | 51 +++++
 rtl/axi4_stream_master_bram.sv | 190 +++++++++++++++++++
 tb/tb_axi4_stream_master_bram.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_bram_pkg.sv
// Shared definitions for the AXI4-Stream <-> BRAM bridge blocks
// (master-side BRAM reader and slave-side BRAM writer).
package axis_bram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Cycles from a BRAM enable to its read data appearing on Do.
    localparam int BRAM_RD_LATENCY = 1;

endpackage

// File: rtl/axis_skid_fifo2.sv
// Two-entry FIFO between the BRAM read port and the AXI4-Stream master output.
// The head entry is held stable until popped.
module axis_skid_fifo2 #(
    parameter int WIDTH = 33
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);
    assign count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/axi4_stream_master_bram.sv
// Streams a frame of words from a BRAM onto an AXI4-Stream master port.
// Optional macro AXIS_MST_BRAM_LEN_EN adds a per-frame length input in_len.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for in_start; the start cycle itself issues read 0
// ST_READ  | reads still to issue, gated by FIFO + in-flight credit
// ST_DRAIN | all reads issued, beats still pending on the stream
module axi4_stream_master_bram
    import axis_bram_pkg::*;
#(
    parameter  int DATA_NUM   = 600,
    parameter  int DATA_WIDTH = 32,
    localparam int ADDR_WIDTH = ($clog2(DATA_NUM) > 1) ? $clog2(DATA_NUM) : 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    in_start,
    output logic                    out_busy,
    output logic                    out_done,
    output logic                    out_m_tvalid,
    input  logic                    in_m_tready,
    output logic [DATA_WIDTH-1:0]   out_m_tdata,
    output logic [DATA_WIDTH/8-1:0] out_m_tkeep,
    output logic                    out_m_tlast,
    output logic [ADDR_WIDTH-1:0]   out_A,
    output logic                    out_EN,
    output logic [DATA_WIDTH/8-1:0] out_WE,
    input  logic [DATA_WIDTH-1:0]   in_Do
`ifdef AXIS_MST_BRAM_LEN_EN
    ,
    input  logic [ADDR_WIDTH:0]     in_len
`endif
);

    localparam int                  KEEP_W   = DATA_WIDTH / 8;
    localparam int                  LAT      = BRAM_RD_LATENCY;
    localparam logic [ADDR_WIDTH:0] LEN_MAX  = (ADDR_WIDTH + 1)'(DATA_NUM);
    localparam logic [ADDR_WIDTH:0] LEN_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    logic [1:0]            rst_sync_q;
    logic                  rst_ok;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] beat_q, beat_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic                  done_q, done_d;
    logic [LAT-1:0]        rd_pipe_q;
    logic [LAT-1:0]        last_pipe_q;
    logic [ADDR_WIDTH:0]   start_len;
    logic [ADDR_WIDTH:0]   cur_len;
    logic [2:0]            inflight;
    logic [2:0]            credit;
    logic                  start_ok;
    logic                  issue;
    logic                  issue_last;
    logic                  handshake;
    logic                  beat_last;
    logic                  fifo_valid;
    logic [1:0]            fifo_count;
    logic [DATA_WIDTH:0]   fifo_dout;

    // Leaving IDLE waits for the synchronised release of aresetn.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_ok = rst_sync_q[1];

`ifdef AXIS_MST_BRAM_LEN_EN
    assign start_len = (in_len > LEN_MAX) ? LEN_MAX : in_len;
`else
    assign start_len = LEN_MAX;
`endif

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + {2'b00, rd_pipe_q[i]};
        end
    end

    // Credit counts the slot freed by this cycle's pop, so a full-rate stream is sustained.
    assign handshake  = fifo_valid && in_m_tready;
    assign credit     = {1'b0, fifo_count} + inflight - {2'b00, handshake};
    assign start_ok   = (state_q == ST_IDLE) && in_start && rst_ok;
    assign cur_len    = (state_q == ST_IDLE) ? start_len : len_q;
    assign issue      = (start_ok && (start_len != '0)) ||
                        ((state_q == ST_READ) && (credit < 3'd2));
    assign issue_last = issue && ({1'b0, addr_q} == (cur_len - LEN_ONE));
    assign beat_last  = ({1'b0, beat_q} == (len_q - LEN_ONE));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        len_d   = len_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    len_d  = start_len;
                    beat_d = '0;
                    if (start_len == '0) begin
                        done_d = 1'b1;
                    end else if (issue_last) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_READ;
                        addr_d  = addr_q + ADDR_ONE;
                    end
                end
            end
            ST_READ: begin
                if (issue) begin
                    if (issue_last) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
            end
            ST_DRAIN: begin
            end
            default: state_d = ST_IDLE;
        endcase
        if (handshake) begin
            if (beat_last) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                addr_d  = '0;
                beat_d  = '0;
            end else begin
                beat_d = beat_q + ADDR_ONE;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            beat_q      <= '0;
            len_q       <= '0;
            done_q      <= 1'b0;
            rd_pipe_q   <= '0;
            last_pipe_q <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            beat_q         <= beat_d;
            len_q          <= len_d;
            done_q         <= done_d;
            rd_pipe_q[0]   <= issue;
            last_pipe_q[0] <= issue_last;
            for (int i = 1; i < LAT; i++) begin
                rd_pipe_q[i]   <= rd_pipe_q[i-1];
                last_pipe_q[i] <= last_pipe_q[i-1];
            end
        end
    end

    axis_skid_fifo2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push_i  (rd_pipe_q[LAT-1]),
        .din_i   ({last_pipe_q[LAT-1], in_Do}),
        .pop_i   (handshake),
        .dout_o  (fifo_dout),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign out_busy     = (state_q != ST_IDLE);
    assign out_done     = done_q;
    assign out_m_tvalid = fifo_valid;
    assign out_m_tdata  = fifo_valid ? fifo_dout[DATA_WIDTH-1:0] : '0;
    assign out_m_tlast  = fifo_valid && fifo_dout[DATA_WIDTH];
    assign out_m_tkeep  = {KEEP_W{fifo_valid}};
    assign out_A        = addr_q;
    assign out_EN       = issue;
    assign out_WE       = '0;

endmodule

// File: tb/tb_axi4_stream_master_bram.sv
// Bench for axi4_stream_master_bram: an 8-word instance checked every cycle against a
// queue model, and a 1-word instance checked with directed expectations.
module tb_axi4_stream_master_bram;

    localparam int DW = 32;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic          start8 = 1'b0, tready8 = 1'b0;
    logic          busy8, done8, tvalid8, tlast8, en8;
    logic [DW-1:0] tdata8, do8;
    logic [3:0]    keep8, we8;
    logic [2:0]    a8;

    logic          start1 = 1'b0, tready1 = 1'b0;
    logic          busy1, done1, tvalid1, tlast1, en1;
    logic [DW-1:0] tdata1, do1;
    logic [3:0]    keep1, we1;
    logic [0:0]    a1;

`ifdef AXIS_MST_BRAM_LEN_EN
    logic [3:0] len8 = 4'd8;
    logic [1:0] len1 = 2'd1;
`endif

    axi4_stream_master_bram #(.DATA_NUM(8), .DATA_WIDTH(DW)) dut8 (
        .aclk(aclk), .aresetn(aresetn), .in_start(start8), .out_busy(busy8),
        .out_done(done8), .out_m_tvalid(tvalid8), .in_m_tready(tready8),
        .out_m_tdata(tdata8), .out_m_tkeep(keep8), .out_m_tlast(tlast8),
        .out_A(a8), .out_EN(en8), .out_WE(we8), .in_Do(do8)
`ifdef AXIS_MST_BRAM_LEN_EN
        , .in_len(len8)
`endif
    );

    axi4_stream_master_bram #(.DATA_NUM(1), .DATA_WIDTH(DW)) dut1 (
        .aclk(aclk), .aresetn(aresetn), .in_start(start1), .out_busy(busy1),
        .out_done(done1), .out_m_tvalid(tvalid1), .in_m_tready(tready1),
        .out_m_tdata(tdata1), .out_m_tkeep(keep1), .out_m_tlast(tlast1),
        .out_A(a1), .out_EN(en1), .out_WE(we1), .in_Do(do1)
`ifdef AXIS_MST_BRAM_LEN_EN
        , .in_len(len1)
`endif
    );

    // BRAM contents: word i holds i + 0x100, one cycle read latency
    always @(posedge aclk) if (en8) do8 <= 32'h100 + 32'(a8);
    always @(posedge aclk) if (en1) do1 <= 32'h100 + 32'(a1);

    int checks = 0, failures = 0;

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    function automatic int model_len8();
`ifdef AXIS_MST_BRAM_LEN_EN
        return (len8 > 4'd8) ? 8 : int'(len8);
`else
        return 8;
`endif
    endfunction

    logic [DW:0]   expq[$];
    bit            active = 1'b0, done_exp = 1'b0, prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    int            next_addr = 0, frame_len = 0, reads = 0, cyc = 0;
    int            hs_cyc[$], starts[$], dones[$];
    logic [DW-1:0] data_seen[$];

    // Frame model for the 8-word instance: expected words queued at start, popped per handshake.
    always @(negedge aclk) begin
        bit accept;
        int fl;
        cyc++;
        if (!aresetn) begin
            chk({busy8, done8, tvalid8, tlast8, en8, tdata8, keep8, we8, a8} == '0,
                "reset_outputs", longint'({busy8, done8, tvalid8, tlast8, en8, tdata8}), 0);
            expq.delete();
            active = 1'b0; done_exp = 1'b0; prev_stall = 1'b0; next_addr = 0;
        end else begin
            chk(done8 == done_exp, "done_pulse", longint'(done8), longint'(done_exp));
            if (done8) dones.push_back(cyc);
            chk(busy8 == active, "busy", longint'(busy8), longint'(active));
            chk(keep8 == (tvalid8 ? 4'hF : 4'h0), "tkeep", longint'(keep8), tvalid8 ? 15 : 0);
            chk(we8 == 4'h0, "bram_we", longint'(we8), 0);
            if (prev_stall) begin
                chk(tvalid8 == 1'b1, "tvalid_hold", longint'(tvalid8), 1);
                chk(tdata8 == prev_data, "tdata_hold", longint'(tdata8), longint'(prev_data));
                chk(tlast8 == prev_last, "tlast_hold", longint'(tlast8), longint'(prev_last));
            end
            accept = start8 && !active;
            fl = model_len8();
            if (accept) begin
                next_addr = 0;
                frame_len = fl;
            end
            if (en8) begin
                reads++;
                chk((active || accept) && next_addr < frame_len && int'(a8) == next_addr,
                    "rd_addr", longint'(a8), longint'(next_addr));
                next_addr++;
            end
            done_exp = 1'b0;
            if (tvalid8 && tready8) begin
                chk(expq.size() != 0, "beat_expected", longint'(tdata8), 0);
                if (expq.size() != 0) begin
                    logic [DW:0] e;
                    e = expq.pop_front();
                    chk(tdata8 == e[DW-1:0], "tdata", longint'(tdata8), longint'(e[DW-1:0]));
                    chk(tlast8 == e[DW], "tlast", longint'(tlast8), longint'(e[DW]));
                    hs_cyc.push_back(cyc);
                    data_seen.push_back(tdata8);
                    if (e[DW]) begin
                        done_exp = 1'b1;
                        active   = 1'b0;
                    end
                end
            end
            prev_stall = tvalid8 && !tready8;
            prev_data  = tdata8;
            prev_last  = tlast8;
            if (accept) begin
                starts.push_back(cyc);
                if (fl == 0) begin
                    done_exp = 1'b1;
                end else begin
                    active = 1'b1;
                    for (int i = 0; i < fl; i++)
                        expq.push_back({1'(i == fl - 1), DW'(32'h100 + i)});
                end
            end
        end
    end

    int            beats1 = 0, dones1 = 0;
    logic [DW-1:0] last_data1 = '0;
    logic          last_tlast1 = 1'b0;

    always @(negedge aclk) begin
        if (aresetn) begin
            chk(keep1 == (tvalid1 ? 4'hF : 4'h0) && we1 == 4'h0, "dut1_keep_we",
                longint'({keep1, we1}), tvalid1 ? 240 : 0);
            if (tvalid1 && tready1) begin
                beats1++;
                last_data1  = tdata1;
                last_tlast1 = tlast1;
            end
            if (done1) dones1++;
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done8 && n < 60) begin
            step();
            n++;
        end
        chk(done8 == 1'b1, nm, longint'(done8), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, n;
        repeat (3) step();
        aresetn = 1'b1;
        repeat (4) step();

        // Full-rate frame, then a start coincident with out_done
        tready8 = 1'b1;
        start8  = 1'b1;
        step();
        start8 = 1'b0;
        wait_done("t1_done");
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        chk(hs_cyc.size() == 8, "t1_beats", hs_cyc.size(), 8);
        chk(hs_cyc[0] == starts[0] + 2, "t1_first_beat_cycle", hs_cyc[0] - starts[0], 2);
        chk(hs_cyc[7] == starts[0] + 9, "t1_last_beat_cycle", hs_cyc[7] - starts[0], 9);
        chk(dones[0] == starts[0] + 10, "t1_done_cycle", dones[0] - starts[0], 10);
        chk(data_seen[0] == 32'h100, "t1_first_data", longint'(data_seen[0]), 'h100);
        chk(data_seen[7] == 32'h107, "t1_last_data", longint'(data_seen[7]), 'h107);
        chk(starts.size() == 2 && starts[1] == dones[0], "t1_restart_on_done",
            starts.size(), 2);

        // tready 1,0,0 repeating on the second frame
        n = 0;
        while (!done8 && n < 90) begin
            tready8 = (n % 3 == 0);
            step();
            n++;
        end
        chk(done8 == 1'b1, "t2_done", longint'(done8), 1);
        chk(hs_cyc.size() == 16, "t2_beats", hs_cyc.size(), 16);
        chk(data_seen[15] == 32'h107, "t2_last_data", longint'(data_seen[15]), 'h107);

        // Long stall right after start
        step();
        tready8 = 1'b0;
        reads   = 0;
        start8  = 1'b1;
        step();
        start8 = 1'b0;
        repeat (20) step();
        chk(reads <= 2, "t3_reads_while_stalled", reads, 2);
        chk(tvalid8 == 1'b1, "t3_tvalid_while_stalled", longint'(tvalid8), 1);
        tready8 = 1'b1;
        wait_done("t3_done");
        chk(hs_cyc.size() == 24, "t3_beats", hs_cyc.size(), 24);
        chk(reads == 8, "t3_total_reads", reads, 8);

        // Reset while beat 3 is presented, then a clean frame from address 0
        step();
        n0 = hs_cyc.size();
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        n = 0;
        while (hs_cyc.size() < n0 + 3 && n < 20) begin
            step();
            n++;
        end
        chk(hs_cyc.size() == n0 + 3, "t4_reach_beat3", hs_cyc.size() - n0, 3);
        chk(tvalid8 == 1'b1 && tdata8 == 32'h103, "t4_beat3_presented", longint'(tdata8), 'h103);
        aresetn = 1'b0;
        #1;
        chk({busy8, tvalid8, tlast8, en8, tdata8} == '0, "t4_outputs_in_reset",
            longint'({busy8, tvalid8, tlast8, en8, tdata8}), 0);
        step();
        step();
        aresetn = 1'b1;
        repeat (4) step();
        n1 = data_seen.size();
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        wait_done("t4_done");
        chk(data_seen.size() == n1 + 8, "t4_beats_after_reset", data_seen.size() - n1, 8);
        chk(data_seen[n1] == 32'h100, "t4_restart_data", longint'(data_seen[n1]), 'h100);

        // One-word instance with start held while busy
        step();
        tready1 = 1'b1;
        start1  = 1'b1;
        step();
        step();
        step();
        start1 = 1'b0;
        repeat (8) step();
        chk(beats1 == 1, "t5_beats", beats1, 1);
        chk(last_tlast1 == 1'b1, "t5_tlast", longint'(last_tlast1), 1);
        chk(last_data1 == 32'h100, "t5_data", longint'(last_data1), 'h100);
        chk(dones1 == 1, "t5_dones", dones1, 1);
        chk(busy1 == 1'b0, "t5_idle_after", longint'(busy1), 0);

`ifdef AXIS_MST_BRAM_LEN_EN
        // Runtime frame lengths 3 and 0
        n1 = data_seen.size();
        len8 = 4'd3;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        wait_done("t6_len3_done");
        chk(data_seen.size() == n1 + 3, "t6_len3_beats", data_seen.size() - n1, 3);
        chk(data_seen[n1 + 2] == 32'h102, "t6_len3_last", longint'(data_seen[n1 + 2]), 'h102);
        step();
        n1 = data_seen.size();
        len8 = 4'd0;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        chk(done8 == 1'b1, "t6_len0_done", longint'(done8), 1);
        chk(busy8 == 1'b0, "t6_len0_busy", longint'(busy8), 0);
        repeat (5) step();
        chk(data_seen.size() == n1, "t6_len0_no_beats", data_seen.size() - n1, 0);
        len8 = 4'd8;
`endif

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
